// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: buffers 32-bit big-endian message words, applies padding and
// the 64-bit length field, and sequences 512-bit blocks through an external round core.
module sha256_msg_feeder (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         in_ready,
  output logic [255:0] core_H_in,
  output logic [511:0] core_M_in,
  output logic         core_start,
  input  logic [255:0] core_H_out,
  input  logic         core_done,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {FILL, PADZ, HASH, WAIT} state_t;

  state_t         state;
  logic [31:0]    blk [16];
  logic [3:0]     widx;
  logic [4:0]     used;
  logic [63:0]    byte_cnt;
  logic [255:0]   chain;
  logic           first_blk;
  logic           pad80_pend;
  logic           fin;
  logic           pad_pend;
  logic [2:0]     nb;
  logic [31:0]    last_word;
  logic [63:0]    bit_len;

  // Final word: keep the valid bytes, drop in the 0x80 marker, zero everything after it.
  always_comb begin
    nb = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    case (nb)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
    bit_len = {byte_cnt[60:0], 3'b000};
  end

  always_comb begin
    core_M_in = '0;
    for (int i = 0; i < 16; i++) core_M_in[511 - 32*i -: 32] = blk[i];
  end

  assign in_ready  = (state == FILL);
  assign core_H_in = first_blk ? IV : chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      for (int i = 0; i < 16; i++) blk[i] <= '0;
      widx         <= '0;
      used         <= '0;
      byte_cnt     <= '0;
      chain        <= '0;
      first_blk    <= 1'b1;
      pad80_pend   <= 1'b0;
      fin          <= 1'b0;
      pad_pend     <= 1'b0;
      core_start   <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      core_start   <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        FILL: begin
          if (in_valid) begin
            busy <= 1'b1;
            if (!in_last) begin
              blk[widx] <= in_data;
              byte_cnt  <= byte_cnt + 64'd4;
              if (widx == 4'd15) begin
                fin        <= 1'b0;
                core_start <= 1'b1;
                state      <= HASH;
              end else begin
                widx <= widx + 4'd1;
              end
            end else begin
              blk[widx] <= last_word;
              byte_cnt  <= byte_cnt + {61'd0, nb};
              // A full final word pushes the marker into the next word, or the next block.
              if (nb != 3'd4) begin
                used <= {1'b0, widx} + 5'd1;
              end else if (widx == 4'd15) begin
                pad80_pend <= 1'b1;
                used       <= 5'd16;
              end else begin
                blk[widx + 4'd1] <= 32'h8000_0000;
                used             <= {1'b0, widx} + 5'd2;
              end
              state <= PADZ;
            end
          end
        end
        PADZ: begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) >= used) blk[i] <= '0;
          end
          if (used <= 5'd14) begin
            blk[14] <= bit_len[63:32];
            blk[15] <= bit_len[31:0];
            fin     <= 1'b1;
          end else begin
            fin      <= 1'b0;
            pad_pend <= 1'b1;
          end
          core_start <= 1'b1;
          state      <= HASH;
        end
        HASH: state <= WAIT;
        WAIT: begin
          if (core_done) begin
            chain     <= core_H_out;
            first_blk <= 1'b0;
            if (fin) begin
              digest       <= core_H_out;
              digest_valid <= 1'b1;
              byte_cnt     <= '0;
              first_blk    <= 1'b1;
              fin          <= 1'b0;
              busy         <= 1'b0;
              widx         <= '0;
              state        <= FILL;
            end else if (pad_pend) begin
              for (int i = 1; i < 14; i++) blk[i] <= '0;
              blk[0]     <= pad80_pend ? 32'h8000_0000 : 32'h0;
              blk[14]    <= bit_len[63:32];
              blk[15]    <= bit_len[31:0];
              pad_pend   <= 1'b0;
              pad80_pend <= 1'b0;
              fin        <= 1'b1;
              core_start <= 1'b1;
              state      <= HASH;
            end else begin
              widx  <= '0;
              state <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Self-checking bench for sha256_msg_feeder; the bench models the SHA-256 round core
// (compression function with variable latency) and checks blocks, chaining and digests.
module tb_sha256_msg_feeder;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic         in_ready;
  logic [255:0] core_H_in;
  logic [511:0] core_M_in;
  logic         core_start;
  logic [255:0] core_H_out = '0;
  logic         core_done = 1'b0;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  sha256_msg_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_nbytes(in_nbytes),
    .in_ready(in_ready),
    .core_H_in(core_H_in), .core_M_in(core_M_in), .core_start(core_start),
    .core_H_out(core_H_out), .core_done(core_done),
    .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Core model: captures H/M on core_start, answers after a varying latency,
  // flags any change of H/M inside the window, and can fire spurious done pulses.
  int           n_starts = 0;
  int           stab_err = 0;
  int           spur_req = 0;
  int           spur_done = 0;
  logic [255:0] h_log [16];
  logic [511:0] m_log [16];
  logic [255:0] res_log [16];
  logic [255:0] h_cap, res;
  logic [511:0] m_cap;
  logic         active = 1'b0;
  int           lat = 0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (!rst_n) begin
      active    = 1'b0;
      spur_done = spur_req;
    end else if (core_start) begin
      h_cap = core_H_in;
      m_cap = core_M_in;
      res   = sha_compress(h_cap, m_cap);
      h_log[n_starts % 16]   = h_cap;
      m_log[n_starts % 16]   = m_cap;
      res_log[n_starts % 16] = res;
      lat    = 6 + (n_starts % 4) * 5;
      n_starts++;
      active = 1'b1;
    end else if (active) begin
      if (core_H_in !== h_cap || core_M_in !== m_cap) stab_err++;
      if (lat <= 1) begin
        core_done  = 1'b1;
        core_H_out = res;
        active     = 1'b0;
      end else begin
        lat--;
      end
    end else if (spur_done != spur_req) begin
      core_done  = 1'b1;
      core_H_out = {8{32'hDEADBEEF}};
      spur_done  = spur_req;
    end
  end

  int acc_cnt = 0;
  int dv_cnt = 0;
  int dv_rdy_err = 0;

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (digest_valid) begin
      dv_cnt++;
      if (!in_ready) dv_rdy_err++;
    end
  end

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting, expected event never came", name);
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
    int   n;
    logic got;
    in_data = d; in_valid = 1'b1; in_last = l; in_nbytes = nb;
    got = 1'b0; n = 0;
    while (!got && n < 2000) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!got) note_timeout("accept");
  endtask

  task automatic wait_digest(output logic [255:0] d);
    int   n;
    logic got;
    got = 1'b0; n = 0; d = '0;
    while (!got && n < 3000) begin
      @(negedge clk);
      if (digest_valid) begin
        got = 1'b1;
        d   = digest;
      end
      n++;
    end
    if (!got) note_timeout("digest_valid");
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    check_output({tag, " in_ready"}, 512'(in_ready), 512'(1'b1));
    check_output({tag, " core_start"}, 512'(core_start), 512'(1'b0));
    check_output({tag, " core_H_in"}, 512'(core_H_in), 512'(IV));
    check_output({tag, " core_M_in"}, core_M_in, 512'd0);
    check_output({tag, " digest"}, 512'(digest), 512'd0);
    check_output({tag, " digest_valid"}, 512'(digest_valid), 512'(1'b0));
    check_output({tag, " busy"}, 512'(busy), 512'(1'b0));
  endtask

  typedef struct {
    logic [31:0]  base;
    logic [31:0]  step;
    int           nwords;
    logic [2:0]   nbytes;
    int           starts;
    int           xidx;
    logic [31:0]  xval;
    logic [31:0]  w0;
    logic [31:0]  w14;
    logic [31:0]  w15;
    logic         known;
    logic [255:0] dig;
  } vec_t;

  vec_t vecs [6];

  // Non-final words carry in_nbytes=1, which the feeder must ignore.
  task automatic apply_stimulus(input vec_t v, output logic [255:0] d);
    for (int i = 0; i < v.nwords; i++) begin
      if (i == v.nwords - 1) send_word(v.base + 32'(i) * v.step, 1'b1, v.nbytes);
      else                   send_word(v.base + 32'(i) * v.step, 1'b0, 3'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_digest(d);
  endtask

  task automatic check_vector(input int k, input vec_t v, input int s0, input int a0,
                              input int d0, input logic [255:0] d);
    int           li;
    logic [511:0] m;
    string        t;
    t  = $sformatf("vec%0d", k);
    li = (n_starts - 1) % 16;
    m  = m_log[li];
    check_output({t, " starts"}, 512'(n_starts - s0), 512'(v.starts));
    check_output({t, " accepts"}, 512'(acc_cnt - a0), 512'(v.nwords));
    check_output({t, " digest_valid pulses"}, 512'(dv_cnt - d0), 512'd1);
    check_output({t, " word0"}, 512'(m[511:480]), 512'(v.w0));
    check_output({t, " wordx"}, 512'(m[511 - 32*v.xidx -: 32]), 512'(v.xval));
    check_output({t, " word14"}, 512'(m[63:32]), 512'(v.w14));
    check_output({t, " word15"}, 512'(m[31:0]), 512'(v.w15));
    check_output({t, " first H_in"}, 512'(h_log[s0 % 16]), 512'(IV));
    if (v.starts == 2)
      check_output({t, " chained H_in"}, 512'(h_log[(s0 + 1) % 16]), 512'(res_log[s0 % 16]));
    check_output({t, " digest vs core"}, 512'(d), 512'(res_log[li]));
    if (v.known) check_output({t, " digest"}, 512'(d), 512'(v.dig));
    check_output({t, " H/M stable"}, 512'(stab_err), 512'd0);
    check_output({t, " ready with digest_valid"}, 512'(dv_rdy_err), 512'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [255:0] d;
    int s0, a0, d0, n;

    vecs[0] = '{32'h616263FF, 32'h0, 1, 3'd3, 1, 1, 32'h0, 32'h61626380, 32'h0, 32'h18, 1'b1,
                256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad};
    vecs[1] = '{32'hFFFFFFFF, 32'h0, 1, 3'd0, 1, 1, 32'h0, 32'h80000000, 32'h0, 32'h0, 1'b1,
                256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855};
    vecs[2] = '{32'h61626364, 32'h01010101, 14, 3'd4, 2, 13, 32'h0, 32'h0, 32'h0, 32'h1C0, 1'b1,
                256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1};
    vecs[3] = '{32'h00010203, 32'h04040404, 16, 3'd4, 2, 1, 32'h0, 32'h80000000, 32'h0, 32'h200, 1'b0, 256'h0};
    vecs[4] = '{32'h30313233, 32'h01010101, 14, 3'd3, 1, 13, 32'h3d3e3f80, 32'h30313233, 32'h0, 32'h1B8, 1'b0, 256'h0};
    vecs[5] = '{32'hA0B0C0D0, 32'h01010101, 2, 3'd7, 1, 2, 32'h80000000, 32'hA0B0C0D0, 32'h0, 32'h40, 1'b0, 256'h0};

    repeat (3) @(posedge clk);
    #1;
    reset_checks("in reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      s0 = n_starts; a0 = acc_cnt; d0 = dv_cnt;
      apply_stimulus(vecs[k], d);
      check_vector(k, vecs[k], s0, a0, d0, d);
      repeat (2) @(posedge clk);
      #1;
    end

    // 17-word message: spurious done mid-fill, then word 16 held valid through WAIT.
    s0 = n_starts; a0 = acc_cnt; d0 = dv_cnt;
    for (int i = 0; i < 4; i++) send_word(32'hC0DE0000 + 32'(i), 1'b0, 3'd0);
    in_valid = 1'b0;
    spur_req++;
    repeat (5) @(posedge clk);
    #1;
    check_output("spurious fill digest_valid", 512'(dv_cnt - d0), 512'd0);
    check_output("spurious fill in_ready", 512'(in_ready), 512'(1'b1));
    check_output("spurious fill H_in", 512'(core_H_in), 512'(IV));
    for (int i = 4; i < 16; i++) send_word(32'hC0DE0000 + 32'(i), 1'b0, 3'd0);
    send_word(32'hC0DE0010, 1'b1, 3'd4);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_digest(d);
    check_output("seq17 starts", 512'(n_starts - s0), 512'd2);
    check_output("seq17 accepts", 512'(acc_cnt - a0), 512'd17);
    check_output("seq17 blk2 word0", 512'(m_log[(s0 + 1) % 16][511:480]), 512'(32'hC0DE0010));
    check_output("seq17 blk2 word1", 512'(m_log[(s0 + 1) % 16][479:448]), 512'(32'h80000000));
    check_output("seq17 blk2 word15", 512'(m_log[(s0 + 1) % 16][31:0]), 512'(32'h220));
    check_output("seq17 blk1 word15", 512'(m_log[s0 % 16][31:0]), 512'(32'hC0DE000F));
    check_output("seq17 chained H_in", 512'(h_log[(s0 + 1) % 16]), 512'(res_log[s0 % 16]));
    check_output("seq17 digest", 512'(d), 512'(res_log[(s0 + 1) % 16]));
    check_output("seq17 H/M stable", 512'(stab_err), 512'd0);

    // Spurious done while idle.
    d0 = dv_cnt;
    spur_req++;
    repeat (5) @(posedge clk);
    #1;
    check_output("spurious idle digest_valid", 512'(dv_cnt - d0), 512'd0);
    check_output("spurious idle busy", 512'(busy), 512'(1'b0));
    check_output("spurious idle digest held", 512'(digest), 512'(d));

    // Reset in the middle of WAIT.
    s0 = n_starts; d0 = dv_cnt;
    send_word(32'h61626300, 1'b1, 3'd3);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n = 0;
    while (n_starts == s0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n_starts == s0) note_timeout("core_start before reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    reset_checks("mid-WAIT reset");
    repeat (30) @(posedge clk);
    #1;
    check_output("reset no digest_valid", 512'(dv_cnt - d0), 512'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    s0 = n_starts; a0 = acc_cnt; d0 = dv_cnt;
    apply_stimulus(vecs[0], d);
    check_vector(6, vecs[0], s0, a0, d0, d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
